free_list_mw: RTL and testbench

Multi-way physical-register free list for the superscalar R10K pipeline. Each cycle it hands up to DISPATCH_W free pregs to the decoder/map table and accepts up to RETIRE_W freed pregs from the ROB. It exposes its head pointer so the branch stack can checkpoint it, and it restores that pointer on misprediction. Occupancy is derived from wrap-bit head/tail pointers, so recovery is always self-consistent.

---
 rtl/free_list_mw_pkg.sv | 26 ++
 rtl/free_list_mw_chk.sv | 19 +
 rtl/free_list_mw_prefix_cnt.sv | 24 ++
 rtl/free_list_mw.sv | 175 +++++++++++++++++
 tb/tb_free_list_mw.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/free_list_mw_pkg.sv
// Shared constants, width helpers and pointer type for the multi-way free list.
package fl_pkg;

    localparam int DEF_PRF_NUM    = 64;
    localparam int DEF_ARF_NUM    = 32;
    localparam int DEF_DISPATCH_W = 2;
    localparam int DEF_RETIRE_W   = 2;

    // Pointer carries one extra wrap bit above the storage index.
    function automatic int fl_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int fl_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int fl_pop_w(input int lanes);
        return $clog2(lanes + 1);
    endfunction

    localparam int DEF_PTR_W = fl_ptr_w(DEF_PRF_NUM - DEF_ARF_NUM);

    typedef logic [DEF_PTR_W-1:0] fl_ptr_t;

endpackage

// File: rtl/free_list_mw_chk.sv
// Protocol checker for the free list request inputs.
module free_list_mw_chk #(
    parameter int DISPATCH_W = 2
) (
    input logic                  clk,
    input logic                  rst,
    input logic [DISPATCH_W-1:0] alloc_req
);

    logic [DISPATCH_W-1:0] req_inc_s;

    assign req_inc_s = alloc_req + DISPATCH_W'(1);

    // A thermometer mask plus one shares no set bit with the mask itself.
    a_alloc_thermometer: assert property (@(posedge clk) disable iff (rst)
        ((alloc_req & req_inc_s) == '0))
        else $error("alloc_req_i is not a thermometer mask");

endmodule

// File: rtl/free_list_mw_prefix_cnt.sv
// Exclusive prefix popcount: pfx lane j holds the number of set bits below j.
module fl_prefix_cnt #(
    parameter int W  = 2,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]    vec,
    output logic [W*CW-1:0] pfx,
    output logic [CW-1:0]   total
);

    logic [CW-1:0] acc_s;

    // Running sum across lanes in lane order.
    always_comb begin
        acc_s = '0;
        pfx   = '0;
        for (int j = 0; j < W; j++) begin
            pfx[j*CW +: CW] = acc_s;
            acc_s           = acc_s + CW'(vec[j]);
        end
        total = acc_s;
    end

endmodule

// File: rtl/free_list_mw.sv
// Multi-way physical-register free list with wrap-bit pointers and head recovery.
// Define FREE_LIST_BYPASS_EN to let same-cycle retired pregs serve allocation lanes.
module free_list_mw
    import fl_pkg::*;
#(
    parameter int PRF_NUM    = DEF_PRF_NUM,
    parameter int ARF_NUM    = DEF_ARF_NUM,
    parameter int DISPATCH_W = DEF_DISPATCH_W,
    parameter int RETIRE_W   = DEF_RETIRE_W,
    localparam int FL_DEPTH  = PRF_NUM - ARF_NUM,
    localparam int PRF_IDX_W = $clog2(PRF_NUM),
    localparam int PTR_W     = fl_ptr_w(FL_DEPTH),
    localparam int CNT_W     = fl_cnt_w(FL_DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DISPATCH_W-1:0]           alloc_req_i,
    output logic [DISPATCH_W*PRF_IDX_W-1:0] free_preg_o,
    output logic [DISPATCH_W-1:0]           free_vld_o,
    output logic                            alloc_stall_o,
    input  logic [RETIRE_W-1:0]             retire_vld_i,
    input  logic [RETIRE_W*PRF_IDX_W-1:0]   retire_preg_i,
    input  logic                            recover_en_i,
    input  logic [PTR_W-1:0]                recover_head_i,
    output logic [PTR_W-1:0]                head_o,
    output logic [CNT_W-1:0]                count_o,
    output logic                            err_overflow_o
);

    localparam int IDX_W = PTR_W - 1;
    localparam int AW    = PTR_W + 2;
    localparam int RCW   = fl_pop_w(RETIRE_W);

    if (FL_DEPTH < 2 || (FL_DEPTH & (FL_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("PRF_NUM-ARF_NUM must be a power of two");
    end
    if (DISPATCH_W > FL_DEPTH) begin : g_bad_dispatch
        $error("DISPATCH_W must not exceed PRF_NUM-ARF_NUM");
    end

    logic [PRF_IDX_W-1:0]  fl_r [FL_DEPTH];
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic                  err_r;

    logic [PTR_W-1:0]      count_s;
    logic [RETIRE_W*RCW-1:0] ret_pfx_s;
    logic [RCW-1:0]        n_ret_s;
    logic [AW-1:0]         k_s;
    logic [AW-1:0]         avail_s;
    logic [AW-1:0]         k_fired_s;
    logic                  fire_s;
    logic                  overflow_s;
    logic [IDX_W-1:0]      rd_idx_s;
    logic [IDX_W-1:0]      wr_idx_s [RETIRE_W];

    fl_prefix_cnt #(
        .W  (RETIRE_W),
        .CW (RCW)
    ) u_ret_pfx (
        .vec   (retire_vld_i),
        .pfx   (ret_pfx_s),
        .total (n_ret_s)
    );

    assign count_s = tail_r - head_r;

    // Requested lane count.
    always_comb begin
        k_s = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            k_s = k_s + AW'(alloc_req_i[i]);
        end
    end

    // Availability, all-or-nothing allocation and overflow detection.
    always_comb begin
`ifdef FREE_LIST_BYPASS_EN
        avail_s = AW'(count_s) + AW'(n_ret_s);
`else
        avail_s = AW'(count_s);
`endif
        fire_s = 1'b0;
        alloc_stall_o = 1'b0;
        if (recover_en_i) begin
            alloc_stall_o = 1'b1;
        end else if (k_s > avail_s) begin
            alloc_stall_o = 1'b1;
        end else begin
            fire_s = 1'b1;
        end
        if (fire_s) begin
            k_fired_s = k_s;
        end else begin
            k_fired_s = '0;
        end
        overflow_s = (AW'(count_s) + AW'(n_ret_s)) > (AW'(FL_DEPTH) + k_fired_s);
    end

    // Per-lane offer: stored entries first, then (in bypass builds) packed retires.
    always_comb begin
        free_preg_o = '0;
        free_vld_o  = '0;
        rd_idx_s    = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            if (AW'(i) < AW'(count_s)) begin
                rd_idx_s = head_r[IDX_W-1:0] + IDX_W'(i);
                free_preg_o[i*PRF_IDX_W +: PRF_IDX_W] = fl_r[rd_idx_s];
            end else begin
`ifdef FREE_LIST_BYPASS_EN
                for (int j = 0; j < RETIRE_W; j++) begin
                    free_preg_o[i*PRF_IDX_W +: PRF_IDX_W] =
                        free_preg_o[i*PRF_IDX_W +: PRF_IDX_W] |
                        ({PRF_IDX_W{retire_vld_i[j] &&
                          ((AW'(ret_pfx_s[j*RCW +: RCW]) + AW'(count_s)) == AW'(i))}} &
                         retire_preg_i[j*PRF_IDX_W +: PRF_IDX_W]);
                end
`else
                free_preg_o[i*PRF_IDX_W +: PRF_IDX_W] = '0;
`endif
            end
            free_vld_o[i] = (AW'(i) < avail_s);
        end
    end

    // Retire lanes pack contiguously starting at tail.
    always_comb begin
        for (int j = 0; j < RETIRE_W; j++) begin
            wr_idx_s[j] = tail_r[IDX_W-1:0] + IDX_W'(ret_pfx_s[j*RCW +: RCW]);
        end
    end

    // Pointer, storage and sticky error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r <= '0;
            tail_r <= PTR_W'(FL_DEPTH);
            err_r  <= 1'b0;
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_r[i] <= PRF_IDX_W'(ARF_NUM + i);
            end
        end else begin
            if (recover_en_i) begin
                head_r <= recover_head_i;
            end else if (fire_s) begin
                head_r <= head_r + PTR_W'(k_s);
            end else begin
                head_r <= head_r;
            end
            if (overflow_s) begin
                err_r <= 1'b1;
            end else begin
                tail_r <= tail_r + PTR_W'(n_ret_s);
                for (int j = 0; j < RETIRE_W; j++) begin
                    if (retire_vld_i[j]) begin
                        fl_r[wr_idx_s[j]] <= retire_preg_i[j*PRF_IDX_W +: PRF_IDX_W];
                    end
                end
            end
        end
    end

    assign head_o         = head_r;
    assign count_o        = CNT_W'(count_s);
    assign err_overflow_o = err_r;

    free_list_mw_chk #(
        .DISPATCH_W (DISPATCH_W)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .alloc_req (alloc_req_i)
    );

endmodule

// File: tb/tb_free_list_mw.sv
// Directed self-checking bench for free_list_mw at default parameters.
module tb_free_list_mw;

    logic        clk;
    logic        rst;
    logic [1:0]  alloc_req_i;
    logic [11:0] free_preg_o;
    logic [1:0]  free_vld_o;
    logic        alloc_stall_o;
    logic [1:0]  retire_vld_i;
    logic [11:0] retire_preg_i;
    logic        recover_en_i;
    logic [5:0]  recover_head_i;
    logic [5:0]  head_o;
    logic [5:0]  count_o;
    logic        err_overflow_o;

    int total_cnt;
    int bad_cnt;

    free_list_mw u_dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_req_i    (alloc_req_i),
        .free_preg_o    (free_preg_o),
        .free_vld_o     (free_vld_o),
        .alloc_stall_o  (alloc_stall_o),
        .retire_vld_i   (retire_vld_i),
        .retire_preg_i  (retire_preg_i),
        .recover_en_i   (recover_en_i),
        .recover_head_i (recover_head_i),
        .head_o         (head_o),
        .count_o        (count_o),
        .err_overflow_o (err_overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_req_i    = 2'b00;
        retire_vld_i   = 2'b00;
        retire_preg_i  = 12'd0;
        recover_en_i   = 1'b0;
        recover_head_i = 6'd0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic drain_all();
        for (int c = 0; c < 16; c++) begin
            alloc_req_i = 2'b11;
            tick();
        end
        alloc_req_i = 2'b00;
        #1;
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst       = 1'b1;
        do_reset();

        // reset state
        chk("rst_count", int'(count_o), 32);
        chk("rst_head", int'(head_o), 0);
        chk("rst_preg0", int'(free_preg_o[5:0]), 32);
        chk("rst_preg1", int'(free_preg_o[11:6]), 33);
        chk("rst_vld", int'(free_vld_o), 3);
        chk("rst_err", int'(err_overflow_o), 0);

        // drain in order
        for (int c = 0; c < 16; c++) begin
            alloc_req_i = 2'b11;
            #1;
            chk("drain_preg0", int'(free_preg_o[5:0]), 32 + 2 * c);
            chk("drain_preg1", int'(free_preg_o[11:6]), 33 + 2 * c);
            chk("drain_stall", int'(alloc_stall_o), 0);
            tick();
        end
        alloc_req_i = 2'b00;
        #1;
        chk("empty_count", int'(count_o), 0);
        chk("empty_head", int'(head_o), 32);
        chk("empty_vld", int'(free_vld_o), 0);
        alloc_req_i = 2'b01;
        #1;
        chk("empty_stall", int'(alloc_stall_o), 1);
        alloc_req_i = 2'b00;

        // sparse retire on lane 1 only
        retire_vld_i  = 2'b10;
        retire_preg_i = {6'd5, 6'd9};
        tick();
        idle();
        #1;
        chk("sparse_count", int'(count_o), 1);
        chk("sparse_preg0", int'(free_preg_o[5:0]), 5);
        chk("sparse_vld", int'(free_vld_o), 1);
        chk("sparse_preg1", int'(free_preg_o[11:6]), 0);

        // recovery with same-cycle retire and suppressed allocation
        do_reset();
        for (int c = 0; c < 3; c++) begin
            alloc_req_i = 2'b11;
            tick();
        end
        chk("rec_setup_head", int'(head_o), 6);
        recover_en_i   = 1'b1;
        recover_head_i = 6'd2;
        retire_vld_i   = 2'b01;
        retire_preg_i  = {6'd0, 6'd7};
        alloc_req_i    = 2'b11;
        #1;
        chk("rec_stall", int'(alloc_stall_o), 1);
        tick();
        idle();
        #1;
        chk("rec_head", int'(head_o), 2);
        chk("rec_count", int'(count_o), 31);
        chk("rec_preg0", int'(free_preg_o[5:0]), 34);
        chk("rec_preg1", int'(free_preg_o[11:6]), 35);
        for (int c = 0; c < 15; c++) begin
            alloc_req_i = 2'b11;
            tick();
        end
        alloc_req_i = 2'b00;
        #1;
        chk("rec_tail_count", int'(count_o), 1);
        chk("rec_tail_preg", int'(free_preg_o[5:0]), 7);
        chk("rec_tail_wrap", int'(head_o), 32);

        // overflow from full
        do_reset();
        retire_vld_i  = 2'b01;
        retire_preg_i = {6'd0, 6'd10};
        tick();
        idle();
        #1;
        chk("ovf_err", int'(err_overflow_o), 1);
        chk("ovf_count", int'(count_o), 32);
        tick();
        tick();
        chk("ovf_sticky", int'(err_overflow_o), 1);
        chk("ovf_preg0", int'(free_preg_o[5:0]), 32);
        do_reset();
        chk("ovf_cleared", int'(err_overflow_o), 0);

        // retire into empty list with same-cycle single allocation
        drain_all();
        chk("byp_empty", int'(count_o), 0);
        retire_vld_i  = 2'b11;
        retire_preg_i = {6'd4, 6'd3};
        alloc_req_i   = 2'b01;
        #1;
`ifdef FREE_LIST_BYPASS_EN
        chk("byp_preg0", int'(free_preg_o[5:0]), 3);
        chk("byp_stall", int'(alloc_stall_o), 0);
        tick();
        idle();
        #1;
        chk("byp_count", int'(count_o), 1);
        chk("byp_next_preg0", int'(free_preg_o[5:0]), 4);
`else
        chk("nobyp_stall", int'(alloc_stall_o), 1);
        chk("nobyp_vld", int'(free_vld_o), 0);
        tick();
        idle();
        #1;
        chk("nobyp_count", int'(count_o), 2);
        chk("nobyp_preg0", int'(free_preg_o[5:0]), 3);
        chk("nobyp_preg1", int'(free_preg_o[11:6]), 4);
`endif

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
